// File: rtl/data_ram_slave_pkg.sv
// Shared constants for the data-memory responder: FSM encodings,
// handshake polarities, default depth and a byte-lane helper.
package data_ram_slave_pkg;

    // Default word-address width (depth = 2**DataMemNumLog2 words)
    localparam int unsigned DataMemNumLog2 = 10;

    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    // Legacy-compatible state encodings
    localparam logic [1:0] DRAM_IDLE   = 2'd0;
    localparam logic [1:0] DRAM_WAIT   = 2'd1;
    localparam logic [1:0] DRAM_ACCESS = 2'd2;

    // Per-lane write strobes: lane enables gated by an overall write enable
    function automatic logic [3:0] lane_we(input logic en, input logic [3:0] sel);
        return sel & {4{en}};
    endfunction

endpackage

// File: rtl/data_ram_slave_if.sv
// Data-memory bus between the mem stage (master) and the RAM responder (slave).
// mem_err_o exists only when DATA_RAM_RANGE_CHECK_EN is defined.
interface data_ram_slave_if;

    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;
`ifdef DATA_RAM_RANGE_CHECK_EN
    logic        mem_err_o;
`endif

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ack_o
`ifdef DATA_RAM_RANGE_CHECK_EN
        , mem_err_o
`endif
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ack_o
`ifdef DATA_RAM_RANGE_CHECK_EN
        , mem_err_o
`endif
    );

endinterface

// File: rtl/data_ram_slave_array.sv
// data_ram_array: four byte-wide storage lanes with per-lane write enables and
// a registered full-word read. Lane 3 holds bits 31:24 (lowest byte address).
module data_ram_array
    import data_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DataMemNumLog2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            we_i,
    input  logic                  re_i,
    input  logic                  rd_zero_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] rd_word;
    logic [31:0] rdata_q;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem_q [DEPTH];

        // Byte-lane write; contents are deliberately not reset
        always_ff @(posedge clk) begin
            if (we_i[g]) begin
                mem_q[addr_i] <= wdata_i[8*g +: 8];
            end
        end

        assign rd_word[8*g +: 8] = mem_q[addr_i];
    end

    // Read register holds the last read word until the next read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? '0 : rd_word;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_slave.sv
// data_ram_slave: responder for mem-stage loads/stores. Captures one request,
// inserts WAIT_CYCLES wait states, performs a byte-masked write or full-word
// read, pulses mem_ack_o and requests a pipeline stall while busy.
// Optional range check: define DATA_RAM_RANGE_CHECK_EN.
module data_ram_slave
    import data_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DataMemNumLog2,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_ram_slave_if.slave bus,
    output logic           stallreq_o
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ack_q, ack_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic                  oor_q;

    logic                  capture;
    logic                  do_access;
    logic                  direct;
    logic                  in_oor;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_wdata;
    logic                  acc_oor;
    logic [3:0]            lane_wen;
    logic                  rd_en;
    logic [31:0]           rdata;

`ifdef DATA_RAM_RANGE_CHECK_EN
    logic                  err_q;
    logic                  unused_addr_bits;
    assign in_oor           = |bus.mem_addr_i[31:ADDR_WIDTH+2];
    assign unused_addr_bits = ^bus.mem_addr_i[1:0];
`else
    logic                  unused_addr_bits;
    assign in_oor           = 1'b0;
    assign unused_addr_bits = ^{bus.mem_addr_i[1:0], bus.mem_addr_i[31:ADDR_WIDTH+2]};
`endif

    assign capture = (state_q == DRAM_IDLE) && (bus.mem_ce_i == ChipEnable) && !ack_q;

    // The access fires on the edge closing the last wait state, so the ack
    // lands in capture+WAIT_CYCLES+1; with no wait states it fires on the
    // capture edge itself and uses the live bus inputs instead of the copies.
    assign do_access = (capture && (WAIT_CYCLES == 0)) ||
                       ((state_q == DRAM_WAIT) && (cnt_q == 4'd0));
    assign direct    = (state_q == DRAM_IDLE);

    assign acc_addr  = direct ? bus.mem_addr_i[ADDR_WIDTH+1:2] : addr_q;
    assign acc_we    = direct ? bus.mem_we_i                   : we_q;
    assign acc_sel   = direct ? bus.mem_sel_i                  : sel_q;
    assign acc_wdata = direct ? bus.mem_data_i                 : wdata_q;
    assign acc_oor   = direct ? in_oor                         : oor_q;

    // Reset on the access edge aborts the write
    assign lane_wen = lane_we(do_access && (acc_we == WriteEnable) && !acc_oor && !rst, acc_sel);
    assign rd_en    = do_access && (acc_we != WriteEnable);

    // Next-state, wait counter and ack generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            DRAM_IDLE: begin
                if (capture) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = DRAM_ACCESS;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = DRAM_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            DRAM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DRAM_ACCESS;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRAM_ACCESS: begin
                state_d = DRAM_IDLE;
            end
            default: begin
                state_d = DRAM_IDLE;
            end
        endcase
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRAM_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    // Request capture; later bus changes are ignored
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= bus.mem_addr_i[ADDR_WIDTH+1:2];
            we_q    <= bus.mem_we_i;
            sel_q   <= bus.mem_sel_i;
            wdata_q <= bus.mem_data_i;
            oor_q   <= in_oor;
        end
    end

`ifdef DATA_RAM_RANGE_CHECK_EN
    // Error flag pulses alongside the ack of an out-of-range request
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= ack_d && acc_oor;
        end
    end

    assign bus.mem_err_o = err_q;
`endif

    data_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (lane_wen),
        .re_i      (rd_en),
        .rd_zero_i (acc_oor),
        .addr_i    (acc_addr),
        .wdata_i   (acc_wdata),
        .rdata_o   (rdata)
    );

    assign bus.mem_data_o = rdata;
    assign bus.mem_ack_o  = ack_q;
    assign stallreq_o     = bus.mem_ce_i & ~ack_q;

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: two instances (WAIT_CYCLES=2 and 0) driven by
// directed requests, checked every cycle against a request-level model.
module tb_data_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, ce, we, ack, stall;
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic [3:0]  sel  [2];
`ifdef DATA_RAM_RANGE_CHECK_EN
    logic [1:0]  err;
`endif

    data_ram_slave_if bus0 ();
    data_ram_slave_if bus1 ();

    assign bus0.mem_ce_i   = ce[0];
    assign bus0.mem_we_i   = we[0];
    assign bus0.mem_addr_i = addr[0];
    assign bus0.mem_sel_i  = sel[0];
    assign bus0.mem_data_i = wd[0];
    assign rd[0]           = bus0.mem_data_o;
    assign ack[0]          = bus0.mem_ack_o;
    assign bus1.mem_ce_i   = ce[1];
    assign bus1.mem_we_i   = we[1];
    assign bus1.mem_addr_i = addr[1];
    assign bus1.mem_sel_i  = sel[1];
    assign bus1.mem_data_i = wd[1];
    assign rd[1]           = bus1.mem_data_o;
    assign ack[1]          = bus1.mem_ack_o;
`ifdef DATA_RAM_RANGE_CHECK_EN
    assign err[0] = bus0.mem_err_o;
    assign err[1] = bus1.mem_err_o;
`endif

    data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst[0]), .bus(bus0.slave), .stallreq_o(stall[0]));
    data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst[1]), .bus(bus1.slave), .stallreq_o(stall[1]));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Request-level model: one outstanding request per instance
    logic [31:0] mm [2][1024];
    bit          pend [2];
    int          ack_cyc [2];
    logic        m_we [2];
    logic [9:0]  m_idx [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_wd [2];
    bit          m_oor [2];
    logic [31:0] exp_data [2];
    bit          live [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; live[k] = 0; exp_data[k] = '0; m_oor[k] = 0; ack_cyc[k] = -1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ea;
            ea = 0;
            if (live[k]) begin
                ea = pend[k] && (cyc == ack_cyc[k]);
                if (ea) begin
                    if (m_we[k]) begin
                        if (!m_oor[k])
                            for (int b = 0; b < 4; b++)
                                if (m_sel[k][b]) mm[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
                    end else begin
                        exp_data[k] = m_oor[k] ? 32'h0 : mm[k][m_idx[k]];
                    end
                    pend[k] = 0;
                end
                check($sformatf("ack[%0d]", k), {31'b0, ack[k]}, {31'b0, ea});
                check($sformatf("data[%0d]", k), rd[k], exp_data[k]);
                check($sformatf("stall[%0d]", k), {31'b0, stall[k]}, {31'b0, ce[k] & ~ea});
`ifdef DATA_RAM_RANGE_CHECK_EN
                check($sformatf("err[%0d]", k), {31'b0, err[k]}, {31'b0, ea & m_oor[k]});
`endif
            end
            if (rst[k]) begin
                pend[k] = 0; exp_data[k] = '0; live[k] = 1;
            end else if (live[k] && !pend[k] && !ea && ce[k]) begin
                pend[k]    = 1;
                ack_cyc[k] = cyc + wait_of(k) + 1;
                m_we[k]    = we[k];
                m_idx[k]   = addr[k][11:2];
                m_sel[k]   = sel[k];
                m_wd[k]    = wd[k];
`ifdef DATA_RAM_RANGE_CHECK_EN
                m_oor[k]   = |addr[k][31:12];
`else
                m_oor[k]   = 0;
`endif
            end
        end
    end

    // One request held until ack; returns read data, latency and error flag
    task automatic req(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] r, output int lat, output logic e);
        int n;
        bit got;
        @(posedge clk); #1;
        ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wd[k] = d;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ack[k]) got = 1; else n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout[%0d] addr=%h: no ack in 40 cycles, ack required", k, a);
        end
        r = rd[k];
        lat = n;
`ifdef DATA_RAM_RANGE_CHECK_EN
        e = err[k];
`else
        e = 1'b0;
`endif
        @(posedge clk); #1;
        ce[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0;
    endtask

    logic [31:0] r;
    int          lat;
    logic        e;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, a1, a2, nack;
        bit got;
        rst = 2'b11; ce = 2'b00; we = 2'b00;
        for (int k = 0; k < 2; k++) begin addr[k] = '0; wd[k] = '0; sel[k] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;

        // Reset state
        @(negedge clk);
        check("reset_ack0", {31'b0, ack[0]}, 32'h0);
        check("reset_ack1", {31'b0, ack[1]}, 32'h0);
        check("reset_data0", rd[0], 32'h0);
        check("reset_data1", rd[1], 32'h0);

        // Write then read, 2 wait states
        req(0, 1'b1, 32'h40, 4'b1111, 32'h12345678, r, lat, e);
        check("w2_write_lat", lat, 3);
        req(0, 1'b0, 32'h40, 4'b0000, 32'h0, r, lat, e);
        check("w2_read_lat", lat, 3);
        check("w2_read_data", r, 32'h12345678);

        // Byte-lane write
        req(0, 1'b1, 32'h40, 4'b0100, 32'hAABBCCDD, r, lat, e);
        req(0, 1'b0, 32'h40, 4'b1111, 32'h0, r, lat, e);
        check("lane_merge", r, 32'h12BB5678);

        // No wait states
        req(1, 1'b1, 32'h10, 4'b1111, 32'hA5A55A5A, r, lat, e);
        req(1, 1'b0, 32'h10, 4'b0000, 32'h0, r, lat, e);
        check("w0_read_lat", lat, 1);
        check("w0_read_data", r, 32'hA5A55A5A);

        // Back-to-back with ce held high
        @(posedge clk); #1;
        ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
        n = 0; nack = 0; a1 = 0; a2 = 0;
        while (nack < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[1]) begin
                nack++;
                if (nack == 1) a1 = cyc; else a2 = cyc;
            end
        end
        @(posedge clk); #1 ce[1] = 1'b0;
        check("b2b_acks", nack, 2);
        check("b2b_spacing", a2 - a1, 2);

        // Abandoned write: ce drops after one cycle
        @(posedge clk); #1;
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h44; sel[0] = 4'hF; wd[0] = 32'hDEADBEEF;
        @(negedge clk);
        @(posedge clk); #1 ce[0] = 1'b0;
        n = 1; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ack[0]) got = 1; else n++;
        end
        check("abandon_ack_seen", {31'b0, got}, 32'h1);
        check("abandon_lat", n, 3);
        req(0, 1'b0, 32'h44, 4'h0, 32'h0, r, lat, e);
        check("abandon_data", r, 32'hDEADBEEF);

        // Reset during wait aborts the write
        req(0, 1'b1, 32'h48, 4'hF, 32'hCAFEF00D, r, lat, e);
        @(posedge clk); #1;
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h48; sel[0] = 4'hF; wd[0] = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst[0] = 1'b1; ce[0] = 1'b0;
        @(posedge clk); #1 rst[0] = 1'b0;
        nack = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[0]) nack++;
        end
        check("rst_abort_noack", nack, 0);
        req(0, 1'b0, 32'h48, 4'h0, 32'h0, r, lat, e);
        check("rst_abort_data", r, 32'hCAFEF00D);

`ifdef DATA_RAM_RANGE_CHECK_EN
        // Out-of-range requests flag an error and leave memory untouched
        req(0, 1'b1, 32'h0, 4'hF, 32'h22222222, r, lat, e);
        check("inrange_err", {31'b0, e}, 32'h0);
        req(0, 1'b1, 32'h1000, 4'hF, 32'h11111111, r, lat, e);
        check("oor_write_err", {31'b0, e}, 32'h1);
        req(0, 1'b0, 32'h0, 4'h0, 32'h0, r, lat, e);
        check("oor_no_update", r, 32'h22222222);
        req(0, 1'b0, 32'h1000, 4'h0, 32'h0, r, lat, e);
        check("oor_read_data", r, 32'h0);
        check("oor_read_err", {31'b0, e}, 32'h1);
`else
        // Upper address bits wrap
        req(0, 1'b1, 32'h1000, 4'hF, 32'h11111111, r, lat, e);
        req(0, 1'b0, 32'h0, 4'h0, 32'h0, r, lat, e);
        check("wrap_data", r, 32'h11111111);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_ram_slave.md
Name: data_ram_slave

Overview:
- Responder end of the data-memory interface that the mem stage drives as initiator for loads and stores.
- Accepts one word-addressed request at a time, inserts programmable wait states, then performs a byte-lane-masked write or a full-word read.
- Returns a one-cycle acknowledge and raises a stall request to the pipeline controller while a request is outstanding.
- Sits beside mem; storage is on-chip and big-endian, matching the MIPS core.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states between capture and access (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- mem_ce_i  in  1  request valid; initiator holds it high until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word
- mem_sel_i  in  4  byte-lane enables; sel[3] = bits 31:24 = lowest byte address
- mem_data_i  in  32  write data
- mem_data_o  out  32  read data, registered, valid while mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse
- stallreq_o  out  1  pipeline stall request to ctrl
- mem_err_o  out  1  present only with DATA_RAM_RANGE_CHECK_EN

Behaviour:
- Reset:
  - On the rst=1 clock edge: state=IDLE, counter=0, mem_data_o=0, mem_ack_o=0, mem_err_o=0.
  - Array contents are not reset.
- States and transitions:
  - IDLE: if mem_ce_i=1 and mem_ack_o=0, capture addr/we/sel/data into internal registers. Go to WAIT with counter=WAIT_CYCLES-1, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: decrement counter; at 0, go to ACCESS.
  - ACCESS: perform the access using the captured values and register mem_ack_o=1 for the next cycle. Go to IDLE.
- Write: update only the byte lanes whose sel bit is 1; other lanes keep their old value.
- Read: return the full word regardless of sel; the mem stage extracts bytes.
- Read data: mem_data_o holds the last read word until the next read completes. It is not cleared after ack. A write leaves mem_data_o unchanged.
- Latency: mem_ack_o is high in cycle N+WAIT_CYCLES+1, where N is the capture cycle.
- stallreq_o = mem_ce_i & ~mem_ack_o (combinational). Pipeline is stalled from the request cycle through the cycle before ack.
- Back-to-back: a request cannot be captured in the ack cycle. The next capture happens at the earliest in the following cycle.
- Input changes after capture are ignored.
- If mem_ce_i drops mid-request, the access still completes and mem_ack_o still pulses.
- Reset mid-request aborts the request: no write, no ack.
- Address bits [1:0] are ignored. Bits above ADDR_WIDTH+1 wrap (are ignored), unless the range check is enabled.

Optional Feature:
- Macro: DATA_RAM_RANGE_CHECK_EN.
- Defined:
  - Any nonzero mem_addr_i[31:ADDR_WIDTH+2] at capture marks the request out-of-range.
  - Out-of-range writes are suppressed; out-of-range reads return 0.
  - mem_err_o pulses together with mem_ack_o.
- Undefined: mem_err_o port is absent and addresses wrap.

Decomposition:
- defines.v additions:
  - state encodings: DRAM_IDLE, DRAM_WAIT, DRAM_ACCESS.
  - `ChipEnable, `WriteEnable.
  - `DataMemNumLog2 as the default ADDR_WIDTH.
- Sub-module data_ram_array: four byte-wide arrays with a per-lane write enable and a synchronous full-word read. The FSM, counter and handshake stay in data_ram_slave.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0x12345678 to address 0x40 with sel=1111 → ack 3 cycles after capture, stallreq_o high until ack. Then read 0x40 → mem_data_o=0x12345678 with ack.
- Byte-lane write: word at 0x40 = 0x12345678; write 0xAABBCCDD with sel=0100 → read returns 0x12BB5678.
- WAIT_CYCLES=0: read is acked in the cycle after capture. Holding ce high for two back-to-back requests → acks are spaced 2 cycles apart, with no capture in the ack cycle.
- Abandoned request: ce drops after 1 cycle of a write of 0xDEADBEEF → ack still pulses and the word is written. Same write with rst asserted in the WAIT state → no ack, word unchanged.
- Wrap, macro off, ADDR_WIDTH=10: write 0x11111111 to 0x1000 → read of 0x0 returns 0x11111111.
- Range check, macro on: write to 0x1000 → mem_err_o=1 with ack and no update. Read of 0x1000 → 0x00000000 with mem_err_o=1.
